rps_round_ctrl: RTL
===================

Name: rps_round_ctrl

Overview:
- Rock-paper-scissors match controller for the lab4 board; sits directly upstream of the 4-digit seven-segment display mux and drives its four 4-bit digit-code inputs (d1 leftmost … d4 rightmost).
- Sequences lock-in, countdown, reveal, round result and match-over.
- Keeps per-player scores, first to 2 wins.
- Consumes debounced single-cycle button pulses and a 1 Hz tick from the existing clock divider.

Parameters:
COUNT_START, 2, countdown start value in ticks; legal range 0..2 (only digits 0/1/2 are displayable).
REVEAL_TICKS, 2, ticks the REVEAL screen is held (1..15).
RESULT_TICKS, 3, ticks the RESULT screen is held (1..15).
WIN_SCORE, 2, round wins needed to take the match (1..2).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-high reset.
tick  in  1  1-cycle enable pulse at 1 Hz.
btn_p1  in  1  debounced 1-cycle lock pulse, player 1.
btn_p2  in  1  debounced 1-cycle lock pulse, player 2.
sel_p1  in  2  player 1 choice: 00 none, 01 R, 10 P, 11 S.
sel_p2  in  2  player 2 choice, same encoding.
d1  out  4  digit code, leftmost.
d2  out  4  digit code.
d3  out  4  digit code.
d4  out  4  digit code, rightmost.
state_o  out  3  current FSM state (debug/LEDs).
round_done  out  1  1-cycle pulse on entry to RESULT.

Behaviour:
- Digit codes:
  - 0000 '0', 0001 '1', 0010 '2', 0100 'P', 0101 'R', 0110 'S', 1000 '-', 1111 blank.
  - No other code is ever driven.
- Choice to letter mapping: R→0101, P→0100, S→0110.
- d1..d4 and state_o are decoded combinationally from registered state only; there is no combinational path from any input to any output.
- Reset (async, any time, including mid-round):
  - state=LOCK; both lock flags, stored choices, scores and tick counter cleared; round_done=0.
  - Outputs immediately: d1=0001, d2=1111, d3=1111, d4=0010.
- LOCK:
  - btn_pX with sel_pX≠00 and player not yet locked → set lock_X, store sel_pX. btn with sel=00 is ignored.
  - After locking, a player's further button presses and selection changes are ignored.
  - Display: d1 = lock_1 ? '-' : '1'; d4 = lock_2 ? '-' : '2'; d2 = d3 = blank.
  - Both buttons in the same cycle lock both players.
  - Clock edge where both flags are (or become) set → COUNT, with counter = COUNT_START.
- COUNT:
  - Display: blank, blank, blank, counter digit.
  - On tick: if counter==0 → REVEAL (counter = REVEAL_TICKS), else counter−1.
  - Buttons are ignored.
  - COUNT_START=0 shows '0' until the first tick.
- REVEAL:
  - Display: d1 = letter of choice 1, d2 = d3 = blank, d4 = letter of choice 2.
  - On tick: counter−1; on the tick where counter==1 → RESULT.
  - On RESULT entry: the winner's score increments (saturating at WIN_SCORE), round_done pulses for 1 cycle, and counter = RESULT_TICKS.
- Judge rules:
  - R beats S, S beats P, P beats R.
  - Equal choices are a draw; no score change on a draw.
- RESULT:
  - Display: d1,d2 = 'P','1' if P1 won; 'P','2' if P2 won; '-','-' on a draw.
  - d3 = score1 digit, d4 = score2 digit.
  - Counts down on ticks as in REVEAL. On expiry:
    - Either score == WIN_SCORE → OVER.
    - Otherwise → LOCK, with lock flags and choices cleared and scores kept.
- OVER:
  - Display: 'P', winner digit ('1'/'2'), '-', '-'.
  - Any button pulse → LOCK, with scores, locks and choices cleared.
  - Ticks are ignored.
- tick coincident with a button: each is handled per the current state only; one state transition per cycle.
- Counter width: 4 bits. state_o encoding: LOCK=0, COUNT=1, REVEAL=2, RESULT=3, OVER=4.

Decomposition:
- Package rps_pkg:
  - Digit-code constants (DIG_0, DIG_1, DIG_2, DIG_P, DIG_R, DIG_S, DIG_DASH, DIG_OFF).
  - Choice encoding constants.
  - State encoding.
  - Result encoding (DRAW, P1_WIN, P2_WIN).
- One sub-module, rps_judge: combinational, takes two 2-bit choices and returns the 2-bit result. It is instanced once and verified standalone over all 9 valid pairs.

Test Plan:
- Reset mid-REVEAL → next cycle state_o=0; outputs 0001,1111,1111,0010; scores 0.
- sel_p1=00 with btn_p1, then sel_p1=01 with btn_p1 → first press ignored (d1 stays 0001), second sets d1=1000; P2 locks 11 → COUNT showing d4=0010, then 0001, then 0000 on successive ticks.
- P1=R, P2=S → REVEAL shows 0101,1111,1111,0110 for 2 ticks; RESULT shows 0100,0001,0001,0000; round_done high exactly one cycle.
- P1=P, P2=P → RESULT shows 1000,1000,0000,0000; scores unchanged; after 3 ticks, state_o=0.
- P2 wins two rounds → OVER shows 0100,0010,1000,1000; ticks ignored; btn_p1 → LOCK with scores 0.
- Both buttons in the same cycle with valid selections → both locks set, and COUNT is entered on the following edge.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors match controller:
// display digit codes, player choices, FSM states and round results.
package rps_pkg;

    localparam logic [3:0] DIG_0    = 4'b0000;
    localparam logic [3:0] DIG_1    = 4'b0001;
    localparam logic [3:0] DIG_2    = 4'b0010;
    localparam logic [3:0] DIG_P    = 4'b0100;
    localparam logic [3:0] DIG_R    = 4'b0101;
    localparam logic [3:0] DIG_S    = 4'b0110;
    localparam logic [3:0] DIG_DASH = 4'b1000;
    localparam logic [3:0] DIG_OFF  = 4'b1111;

    localparam logic [1:0] CH_NONE = 2'b00;
    localparam logic [1:0] CH_R    = 2'b01;
    localparam logic [1:0] CH_P    = 2'b10;
    localparam logic [1:0] CH_S    = 2'b11;

    typedef enum logic [2:0] {
        ST_LOCK   = 3'd0,
        ST_COUNT  = 3'd1,
        ST_REVEAL = 3'd2,
        ST_RESULT = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DRAW   = 2'd0,
        P1_WIN = 2'd1,
        P2_WIN = 2'd2
    } result_t;

    function automatic logic [3:0] choice_letter(input logic [1:0] c);
        case (c)
            CH_R:    return DIG_R;
            CH_P:    return DIG_P;
            CH_S:    return DIG_S;
            default: return DIG_OFF;
        endcase
    endfunction

    // Only 0..2 are displayable; anything larger blanks the digit.
    function automatic logic [3:0] num_digit(input logic [3:0] n);
        case (n)
            4'd0:    return DIG_0;
            4'd1:    return DIG_1;
            4'd2:    return DIG_2;
            default: return DIG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: R beats S, S beats P, P beats R, equal is a draw.
module rps_judge
    import rps_pkg::*;
(
    input  logic [1:0] choice_1,
    input  logic [1:0] choice_2,
    output result_t    result
);

    always_comb begin
        result = DRAW;
        if (choice_1 != choice_2) begin
            if ((choice_1 == CH_R && choice_2 == CH_S) ||
                (choice_1 == CH_S && choice_2 == CH_P) ||
                (choice_1 == CH_P && choice_2 == CH_R))
                result = P1_WIN;
            else
                result = P2_WIN;
        end
    end

endmodule

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors match controller: lock-in, countdown, reveal, result and
// match-over screens driven onto the four seven-segment digit codes.
module rps_round_ctrl
    import rps_pkg::*;
#(
    parameter int unsigned COUNT_START  = 2,
    parameter int unsigned REVEAL_TICKS = 2,
    parameter int unsigned RESULT_TICKS = 3,
    parameter int unsigned WIN_SCORE    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_p1,
    input  logic       btn_p2,
    input  logic [1:0] sel_p1,
    input  logic [1:0] sel_p2,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] d4,
    output logic [2:0] state_o,
    output logic       round_done
);

    localparam logic [3:0] COUNT_INIT  = 4'(COUNT_START);
    localparam logic [3:0] REVEAL_INIT = 4'(REVEAL_TICKS);
    localparam logic [3:0] RESULT_INIT = 4'(RESULT_TICKS);
    localparam logic [1:0] WIN         = 2'(WIN_SCORE);

    state_t     state_q, state_d;
    logic       lock1_q, lock1_d, lock2_q, lock2_d;
    logic [1:0] choice1_q, choice1_d, choice2_q, choice2_d;
    logic [1:0] score1_q, score1_d, score2_q, score2_d;
    logic [3:0] cnt_q, cnt_d;
    logic       round_done_q, round_done_d;
    result_t    round_result;

    rps_judge u_judge (
        .choice_1 (choice1_q),
        .choice_2 (choice2_q),
        .result   (round_result)
    );

    always_comb begin
        state_d      = state_q;
        lock1_d      = lock1_q;
        lock2_d      = lock2_q;
        choice1_d    = choice1_q;
        choice2_d    = choice2_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        cnt_d        = cnt_q;
        round_done_d = 1'b0;
        case (state_q)
            ST_LOCK: begin
                if (btn_p1 && sel_p1 != CH_NONE && !lock1_q) begin
                    lock1_d   = 1'b1;
                    choice1_d = sel_p1;
                end
                if (btn_p2 && sel_p2 != CH_NONE && !lock2_q) begin
                    lock2_d   = 1'b1;
                    choice2_d = sel_p2;
                end
                if (lock1_d && lock2_d) begin
                    state_d = ST_COUNT;
                    cnt_d   = COUNT_INIT;
                end
            end
            ST_COUNT: begin
                if (tick) begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_REVEAL;
                        cnt_d   = REVEAL_INIT;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ST_REVEAL: begin
                if (tick) begin
                    if (cnt_q <= 4'd1) begin
                        state_d      = ST_RESULT;
                        cnt_d        = RESULT_INIT;
                        round_done_d = 1'b1;
                        if (round_result == P1_WIN && score1_q < WIN)
                            score1_d = score1_q + 2'd1;
                        if (round_result == P2_WIN && score2_q < WIN)
                            score2_d = score2_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ST_RESULT: begin
                if (tick) begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d = 4'd0;
                        if (score1_q == WIN || score2_q == WIN) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d   = ST_LOCK;
                            lock1_d   = 1'b0;
                            lock2_d   = 1'b0;
                            choice1_d = CH_NONE;
                            choice2_d = CH_NONE;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ST_OVER: begin
                // A new match starts from scratch on any button press.
                if (btn_p1 || btn_p2) begin
                    state_d   = ST_LOCK;
                    lock1_d   = 1'b0;
                    lock2_d   = 1'b0;
                    choice1_d = CH_NONE;
                    choice2_d = CH_NONE;
                    score1_d  = 2'd0;
                    score2_d  = 2'd0;
                    cnt_d     = 4'd0;
                end
            end
            default: state_d = ST_LOCK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_LOCK;
            lock1_q      <= 1'b0;
            lock2_q      <= 1'b0;
            choice1_q    <= CH_NONE;
            choice2_q    <= CH_NONE;
            score1_q     <= 2'd0;
            score2_q     <= 2'd0;
            cnt_q        <= 4'd0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock1_q      <= lock1_d;
            lock2_q      <= lock2_d;
            choice1_q    <= choice1_d;
            choice2_q    <= choice2_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            cnt_q        <= cnt_d;
            round_done_q <= round_done_d;
        end
    end

    // Display decode uses registered state only, so inputs never reach the digits.
    always_comb begin
        d1 = DIG_OFF;
        d2 = DIG_OFF;
        d3 = DIG_OFF;
        d4 = DIG_OFF;
        case (state_q)
            ST_LOCK: begin
                d1 = lock1_q ? DIG_DASH : DIG_1;
                d4 = lock2_q ? DIG_DASH : DIG_2;
            end
            ST_COUNT: d4 = num_digit(cnt_q);
            ST_REVEAL: begin
                d1 = choice_letter(choice1_q);
                d4 = choice_letter(choice2_q);
            end
            ST_RESULT: begin
                case (round_result)
                    P1_WIN: begin d1 = DIG_P;    d2 = DIG_1;    end
                    P2_WIN: begin d1 = DIG_P;    d2 = DIG_2;    end
                    default: begin d1 = DIG_DASH; d2 = DIG_DASH; end
                endcase
                d3 = num_digit({2'b00, score1_q});
                d4 = num_digit({2'b00, score2_q});
            end
            ST_OVER: begin
                d1 = DIG_P;
                d2 = (score1_q == WIN) ? DIG_1 : DIG_2;
                d3 = DIG_DASH;
                d4 = DIG_DASH;
            end
            default: ;
        endcase
    end

    assign state_o    = state_q;
    assign round_done = round_done_q;

endmodule
